// File: rtl/infer_seq_if.sv
// Start/done handshake between the batch sequencer (master) and the inference FSM (slave).
interface infer_seq_if;
    logic       infer_start;
    logic       infer_done;
    logic       infer_busy;
    logic [3:0] pred;

    modport master (
        output infer_start,
        input  infer_done,
        input  infer_busy,
        input  pred
    );

    modport slave (
        input  infer_start,
        output infer_done,
        output infer_busy,
        output pred
    );
endinterface

// File: rtl/infer_seq.sv
// Batch initiator: walks N_IMG images through the start/done handshake and scores predictions.
// Optional watchdog abort is compiled in with `define INFER_SEQ_TIMEOUT_EN.
module infer_seq #(
    parameter int unsigned N_IMG   = 10,
    parameter int unsigned IMG_W   = 4,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned TMO_CYC = 4000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_go,
    input  logic [3:0]       i_label,
    infer_seq_if.master      io_hs,
    output logic [IMG_W-1:0] o_img_idx,
    output logic             o_res_valid,
    output logic [3:0]       o_res_pred,
    output logic             o_res_hit,
    output logic [CNT_W-1:0] o_res_cycles,
    output logic [IMG_W:0]   o_n_correct,
    output logic             o_busy,
    output logic             o_batch_done,
    output logic             o_err_tmo
);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWaitDone, StCapture, StRelease, StNext
    } state_e;

    localparam logic [IMG_W-1:0] LastIdx = IMG_W'(N_IMG - 1);
    // Abort on the edge where the counter would reach TMO_CYC.
    localparam logic [CNT_W-1:0] TmoLim  = CNT_W'(TMO_CYC - 1);

    state_e           r_state;
    logic             r_infer_start;
    logic [CNT_W-1:0] r_cnt;
    logic [IMG_W-1:0] r_img_idx;
    logic             r_res_valid;
    logic [3:0]       r_res_pred;
    logic             r_res_hit;
    logic [CNT_W-1:0] r_res_cycles;
    logic [IMG_W:0]   r_n_correct;
    logic             r_busy;
    logic             r_batch_done;
    logic             r_err_tmo;

    logic w_at_lim;
    logic w_tmo_hit;
    logic w_hit;

    assign w_at_lim = (r_cnt == TmoLim);
    assign w_hit    = (io_hs.pred == i_label);

`ifdef INFER_SEQ_TIMEOUT_EN
    assign w_tmo_hit = w_at_lim;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = w_at_lim;
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_infer_start <= 1'b0;
            r_cnt         <= '0;
            r_img_idx     <= '0;
            r_res_valid   <= 1'b0;
            r_res_pred    <= '0;
            r_res_hit     <= 1'b0;
            r_res_cycles  <= '0;
            r_n_correct   <= '0;
            r_busy        <= 1'b0;
            r_batch_done  <= 1'b0;
            r_err_tmo     <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_go) begin
                        r_img_idx    <= '0;
                        r_n_correct  <= '0;
                        r_batch_done <= 1'b0;
                        r_err_tmo    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= StIssue;
                    end
                end
                StIssue: begin
                    // Hold off while the peer still shows a previous handshake.
                    if (!io_hs.infer_done && !io_hs.infer_busy) begin
                        r_cnt         <= '0;
                        r_infer_start <= 1'b1;
                        r_state       <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (io_hs.infer_done) begin
                        r_state <= StCapture;
                    end else if (w_tmo_hit) begin
                        r_err_tmo     <= 1'b1;
                        r_infer_start <= 1'b0;
                        r_batch_done  <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= StIdle;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StCapture: begin
                    r_res_pred    <= io_hs.pred;
                    r_res_hit     <= w_hit;
                    r_res_cycles  <= r_cnt;
                    r_res_valid   <= 1'b1;
                    r_infer_start <= 1'b0;
                    if (w_hit) begin
                        r_n_correct <= r_n_correct + (IMG_W+1)'(1);
                    end
                    r_state <= StRelease;
                end
                StRelease: begin
                    if (!io_hs.infer_done) begin
                        r_state <= StNext;
                    end
                end
                StNext: begin
                    if (r_img_idx == LastIdx) begin
                        r_batch_done <= 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= StIdle;
                    end else begin
                        r_img_idx <= r_img_idx + IMG_W'(1);
                        r_state   <= StIssue;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_hs.infer_start = r_infer_start;
    assign o_img_idx         = r_img_idx;
    assign o_res_valid       = r_res_valid;
    assign o_res_pred        = r_res_pred;
    assign o_res_hit         = r_res_hit;
    assign o_res_cycles      = r_res_cycles;
    assign o_n_correct       = r_n_correct;
    assign o_busy            = r_busy;
    assign o_batch_done      = r_batch_done;
    assign o_err_tmo         = r_err_tmo;

endmodule

// File: tb/tb_infer_seq.sv
// Directed bench for infer_seq: nominal batch, mismatches, stale handshake, reset, watchdog.
module tb_infer_seq;

    localparam int unsigned N_IMG   = 3;
    localparam int unsigned IMG_W   = 4;
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned TMO_CYC = 20;

    logic             clk;
    logic             rst_n;
    logic             go;
    logic [3:0]       label;
    logic [IMG_W-1:0] img_idx;
    logic             res_valid;
    logic [3:0]       res_pred;
    logic             res_hit;
    logic [CNT_W-1:0] res_cycles;
    logic [IMG_W:0]   n_correct;
    logic             busy;
    logic             batch_done;
    logic             err_tmo;

    int checks;
    int failures;

    infer_seq_if hs_if ();

    infer_seq #(
        .N_IMG  (N_IMG),
        .IMG_W  (IMG_W),
        .CNT_W  (CNT_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_go        (go),
        .i_label     (label),
        .io_hs       (hs_if.master),
        .o_img_idx   (img_idx),
        .o_res_valid (res_valid),
        .o_res_pred  (res_pred),
        .o_res_hit   (res_hit),
        .o_res_cycles(res_cycles),
        .o_n_correct (n_correct),
        .o_busy      (busy),
        .o_batch_done(batch_done),
        .o_err_tmo   (err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (hs_if.infer_start !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(hs_if.infer_start), 32'd1);
    endtask

    task automatic wait_batch_done(input string tag);
        int n = 0;
        while (batch_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(batch_done), 32'd1);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // Peer model: done rises after lat cycles of start, drops once start falls.
    task automatic do_image(input int idx, input logic [3:0] lbl, input logic [3:0] prd,
                            input int lat, input bit exp_hit, input int exp_nc,
                            input bit go_during);
        wait_start($sformatf("start_img%0d", idx));
        chk($sformatf("img_idx%0d", idx), 32'(img_idx), 32'(idx));
        label = lbl;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (go_during && i == 0) go = 1'b1;
            if (go_during && i == 1) go = 1'b0;
        end
        if (go_during) begin
            chk("go_ignored_idx", 32'(img_idx), 32'(idx));
            chk("go_ignored_busy", 32'(busy), 32'd1);
        end
        hs_if.infer_done = 1'b1;
        hs_if.pred       = prd;
        @(negedge clk);
        chk("res_valid_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("start_drop", 32'(hs_if.infer_start), 32'd0);
        chk("res_pred", 32'(res_pred), 32'(prd));
        chk("res_hit", 32'(res_hit), 32'(exp_hit));
        chk("res_cycles", 32'(res_cycles), 32'(lat));
        chk("n_correct", 32'(n_correct), 32'(exp_nc));
        hs_if.infer_done = 1'b0;
        @(negedge clk);
        chk("res_valid_pulse", 32'(res_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        go               = 1'b0;
        label            = 4'd0;
        hs_if.infer_done = 1'b0;
        hs_if.infer_busy = 1'b0;
        hs_if.pred       = 4'd0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_start", 32'(hs_if.infer_start), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_hit", 32'(res_hit), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_batch_done", 32'(batch_done), 32'd0);
        chk("rst_err_tmo", 32'(err_tmo), 32'd0);
        chk("rst_img_idx", 32'(img_idx), 32'd0);
        chk("rst_res_pred", 32'(res_pred), 32'd0);
        chk("rst_res_cycles", 32'(res_cycles), 32'd0);
        chk("rst_n_correct", 32'(n_correct), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal batch, all hits, latency 5
        pulse_go();
        chk("go_start_1edge", 32'(hs_if.infer_start), 32'd0);
        chk("go_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("go_start_2edge", 32'(hs_if.infer_start), 32'd1);
        do_image(0, 4'd3, 4'd3, 5, 1'b1, 1, 1'b0);
        do_image(1, 4'd5, 4'd5, 5, 1'b1, 2, 1'b0);
        do_image(2, 4'd9, 4'd9, 5, 1'b1, 3, 1'b0);
        wait_batch_done("nom_batch_done");
        chk("nom_busy", 32'(busy), 32'd0);
        chk("nom_n_correct", 32'(n_correct), 32'd3);
        chk("nom_start_idle", 32'(hs_if.infer_start), 32'd0);

        // Mismatches: labels 7,1,4 vs preds 7,2,4
        pulse_go();
        chk("mm_batch_done_clr", 32'(batch_done), 32'd0);
        chk("mm_n_correct_clr", 32'(n_correct), 32'd0);
        do_image(0, 4'd7, 4'd7, 3, 1'b1, 1, 1'b0);
        do_image(1, 4'd1, 4'd2, 3, 1'b0, 1, 1'b0);
        do_image(2, 4'd4, 4'd4, 3, 1'b1, 2, 1'b0);
        wait_batch_done("mm_batch_done");
        chk("mm_n_correct", 32'(n_correct), 32'd2);
        chk("mm_res_pred_hold", 32'(res_pred), 32'd4);

        // Stale handshake: done held high across go for 4 cycles
        hs_if.infer_done = 1'b1;
        pulse_go();
        for (int i = 0; i < 3; i++) begin
            chk("stale_start_low", 32'(hs_if.infer_start), 32'd0);
            @(negedge clk);
        end
        chk("stale_start_low", 32'(hs_if.infer_start), 32'd0);
        hs_if.infer_done = 1'b0;
        @(negedge clk);
        chk("stale_start_rise", 32'(hs_if.infer_start), 32'd1);

        // go during the batch is ignored; reset during WAIT_DONE of image 1
        do_image(0, 4'd2, 4'd2, 4, 1'b1, 1, 1'b1);
        wait_start("rst_wait_img1");
        chk("rst_pre_idx", 32'(img_idx), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_start", 32'(hs_if.infer_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_img_idx", 32'(img_idx), 32'd0);
        chk("midrst_n_correct", 32'(n_correct), 32'd0);
        chk("midrst_res_pred", 32'(res_pred), 32'd0);
        @(negedge clk);
        chk("midrst_stays_idle", 32'(hs_if.infer_start), 32'd0);

        // Peer never answers
        pulse_go();
        wait_start("tmo_start");
`ifdef INFER_SEQ_TIMEOUT_EN
        for (int i = 0; i < TMO_CYC - 1; i++) begin
            @(negedge clk);
            chk("tmo_res_valid", 32'(res_valid), 32'd0);
        end
        chk("tmo_start_held", 32'(hs_if.infer_start), 32'd1);
        @(negedge clk);
        chk("tmo_start_drop", 32'(hs_if.infer_start), 32'd0);
        chk("tmo_err", 32'(err_tmo), 32'd1);
        chk("tmo_batch_done", 32'(batch_done), 32'd1);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_res_valid_end", 32'(res_valid), 32'd0);
`else
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            chk("hold_start", 32'(hs_if.infer_start), 32'd1);
        end
        chk("hold_err_tmo", 32'(err_tmo), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_batch_done", 32'(batch_done), 32'd0);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("final_err_tmo", 32'(err_tmo), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
